// File: rtl/rev_alu_pkg.sv
// rev_alu_pkg: opcode encodings and flag bundle shared by the reversible ALU pipeline
package rev_alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;
  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;
endpackage

// File: rtl/rev_alu_bit_cell.sv
// rev_alu_bit_cell: one-bit reversible add/sub cell with AND/OR/XOR taps
// Ports: i_a/i_b operand bits, i_sub inverts B, i_cin carry in;
//        o_sum/o_cout adder outputs, o_and/o_or/o_xor logic taps on the uninverted B.
module rev_alu_bit_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sub,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout,
  output logic o_and,
  output logic o_or,
  output logic o_xor
);
  logic w_bx, w_p, w_g;
  // Feynman gate conditionally inverts B for subtraction
  assign w_bx = i_b ^ i_sub;
  // Two cascaded Peres gates form the full adder: propagate/generate, then sum/carry
  assign w_p = i_a ^ w_bx;
  assign w_g = i_a & w_bx;
  assign o_sum = w_p ^ i_cin;
  assign o_cout = (w_p & i_cin) ^ w_g;
  // Toffoli AND, Feynman XOR; OR = AND ^ XOR
  assign o_and = i_a & i_b;
  assign o_xor = i_a ^ i_b;
  assign o_or = o_and ^ o_xor;
endmodule

// File: rtl/rev_alu_pipe.sv
// rev_alu_pipe: two-stage valid/ready pipelined reversible-gate ALU with barrel shifts and flags
// Ports: clk, rst_n (async active-low); in_valid/in_ready input handshake with a, b, op, cin;
//        out_valid/out_ready output handshake with result, flag_c/v/z/n; op_count = completed outputs.
module rev_alu_pipe
  import rev_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic [CNT_W-1:0] op_count
);
  logic r_s1_valid, r_cin, r_out_valid;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [2:0] r_op;
  flags_t r_flags, w_nf;
  logic [CNT_W-1:0] r_op_count;
  logic w_s2_load, w_sub, w_left, w_fill;
  logic [WIDTH:0] w_c;
  logic [WIDTH-1:0] w_sum, w_and, w_or, w_xor, w_a_rev, w_sh_rev, w_shift, w_res;
  logic [SHW-1:0] w_amt;
  logic [WIDTH:0] w_st [SHW+1];
  assign w_s2_load = r_s1_valid & (~r_out_valid | out_ready);
  // Gated by rst_n so the port reads 0 for the whole time reset is held
  assign in_ready = rst_n & (~r_s1_valid | w_s2_load);
  assign w_sub = r_op == OP_SUB;
  assign w_c[0] = r_cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    rev_alu_bit_cell u_cell (
      .i_a(r_a[i]), .i_b(r_b[i]), .i_sub(w_sub), .i_cin(w_c[i]),
      .o_sum(w_sum[i]), .o_cout(w_c[i+1]),
      .o_and(w_and[i]), .o_or(w_or[i]), .o_xor(w_xor[i])
    );
  end
  // One right-shifting Fredkin-mux chain serves all shifts: SHL shifts the bit-reversed
  // operand. The extra LSB catches the last bit shifted out, which is the carry flag.
  assign w_amt = r_b[SHW-1:0];
  assign w_left = r_op == OP_SHL;
  assign w_fill = (r_op == OP_ASR) & r_a[WIDTH-1];
  assign w_st[0] = {w_left ? w_a_rev : r_a, 1'b0};
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign w_a_rev[i] = r_a[WIDTH-1-i];
    assign w_sh_rev[i] = w_st[SHW][WIDTH-i];
  end
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S = 2 ** k;
    assign w_st[k+1] = w_amt[k] ? {{S{w_fill}}, w_st[k][WIDTH:S]} : w_st[k];
  end
  assign w_shift = w_left ? w_sh_rev : w_st[SHW][WIDTH:1];
  always_comb begin
    w_nf = '0;
    w_res = w_shift;
    w_nf.c = w_st[SHW][0];
    if (r_op == OP_AND || r_op == OP_OR || r_op == OP_XOR) begin
      w_res = r_op == OP_AND ? w_and : r_op == OP_OR ? w_or : w_xor;
      w_nf.c = 1'b0;
    end else if (r_op == OP_ADD || w_sub) begin
      w_res = w_sum;
      w_nf.c = w_c[WIDTH];
      // ADD overflows on like-signed operands, SUB on unlike-signed; both need a sign flip
      w_nf.v = ((r_a[WIDTH-1] ^ r_b[WIDTH-1]) == w_sub) & (w_sum[WIDTH-1] ^ r_a[WIDTH-1]);
    end
    w_nf.z = ~|w_res;
    w_nf.n = w_res[WIDTH-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_cin <= 1'b0;
      r_out_valid <= 1'b0;
      r_result <= '0;
      r_flags <= '0;
      r_op_count <= '0;
    end else begin
      if (in_valid && in_ready) begin
        r_s1_valid <= 1'b1;
        r_a <= a;
        r_b <= b;
        r_op <= op;
        r_cin <= cin;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_out_valid <= 1'b1;
        r_result <= w_res;
        r_flags <= w_nf;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready) r_op_count <= r_op_count + 1'b1;
    end
  end
  assign out_valid = r_out_valid;
  assign result = r_result;
  assign flag_c = r_flags.c;
  assign flag_v = r_flags.v;
  assign flag_z = r_flags.z;
  assign flag_n = r_flags.n;
  assign op_count = r_op_count;
endmodule

// File: tb/tb_rev_alu_pipe.sv
// tb_rev_alu_pipe: scoreboard bench driving directed vectors through rev_alu_pipe
module tb_rev_alu_pipe;
  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, XOR_ = 3'b010, ADD_ = 3'b011;
  localparam logic [2:0] SUB_ = 3'b100, SHL_ = 3'b101, SHR_ = 3'b110, ASR_ = 3'b111;
  typedef struct packed {
    logic [31:0] r;
    logic [3:0] f;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 1;
  logic [31:0] a = 0, b = 0, result;
  logic [2:0] op = 0;
  logic flag_c, flag_v, flag_z, flag_n;
  logic [15:0] op_count;
  logic [15:0] exp_cnt = 0;
  exp_t q[$];
  exp_t e;
  int pop_cyc[$];
  int checks = 0, errors = 0, n_acc = 0, cyc = 0;
  logic held = 0, bp_done = 0;
  logic [35:0] held_v;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rev_alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .op_count(op_count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic c, input logic [31:0] er, input logic [3:0] ef);
    int n;
    logic acc;
    op = o; a = x; b = y; cin = c; in_valid = 1;
    q.push_back(exp_t'{er, ef});
    n = 0;
    acc = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else n_acc++;
  endtask
  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else begin
      if (held) chk("hold_stable", {result, flag_c, flag_v, flag_z, flag_n}, held_v);
      held = out_valid & !out_ready;
      held_v = {result, flag_c, flag_v, flag_z, flag_n};
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("result", result, e.r);
          chk("flags_cvzn", {flag_c, flag_v, flag_z, flag_n}, e.f);
        end
        pop_cyc.push_back(cyc);
        exp_cnt++;
      end
    end
  end
  initial begin
    int t0, base, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {out_valid, in_ready, flag_c, flag_v, flag_z, flag_n}, 0);
    chk("rst_result", result, 0);
    chk("rst_count", op_count, 0);
    rst_n = 1;
    #1;
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;
    send(ADD_, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 4'b1010);
    in_valid = 0;
    chk("lat_e0", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_e1", out_valid, 1);
    send(SUB_, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 4'b1100);
    send(SUB_, 32'h5, 32'h7, 1, 32'hFFFFFFFE, 4'b0001);
    send(ASR_, 32'h80000000, 32'h4, 0, 32'hF8000000, 4'b0001);
    send(SHL_, 32'h3, 32'd31, 0, 32'h80000000, 4'b1001);
    send(SHR_, 32'h1, 32'h20, 0, 32'h1, 4'b0000);
    idle(4);
    chk("count_directed", op_count, 6);
    t0 = cyc;
    send(AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 4'b0000);
    send(OR_, 32'h12340000, 32'h00005678, 1, 32'h12345678, 4'b0000);
    send(XOR_, 32'hFFFF0000, 32'hFF00FF00, 0, 32'h00FFFF00, 4'b0000);
    send(ADD_, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 4'b0101);
    send(SHR_, 32'h3, 32'h1, 0, 32'h1, 4'b1000);
    send(ASR_, 32'h7FFFFFF0, 32'h4, 0, 32'h07FFFFFF, 4'b0000);
    send(ADD_, 32'h1, 32'h2, 1, 32'h4, 4'b0000);
    send(SHL_, 32'h80000001, 32'h1, 0, 32'h2, 4'b1000);
    chk("tput_accept_cycles", cyc - t0, 8);
    idle(4);
    chk("tput_consecutive", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-8], 7);
    chk("count_tput", op_count, 14);
    out_ready = 0;
    base = n_acc;
    fork
      begin
        send(ADD_, 32'd10, 32'd20, 0, 32'h1E, 4'b0000);
        send(SUB_, 32'd10, 32'd20, 1, 32'hFFFFFFF6, 4'b0001);
        send(XOR_, 32'hAAAA5555, 32'hFFFFFFFF, 0, 32'h5555AAAA, 4'b0000);
        in_valid = 0;
        bp_done = 1;
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    chk("bp_accepted", n_acc - base, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_first_held", result, 32'h1E);
    chk("bp_count", op_count, 14);
    out_ready = 1;
    n = 0;
    while (!bp_done && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("bp_done", bp_done, 1);
    idle(4);
    chk("count_bp", op_count, 17);
    send(ADD_, 32'h1, 32'h1, 0, 32'h2, 4'b0000);
    send(ADD_, 32'h2, 32'h2, 0, 32'h4, 4'b0000);
    in_valid = 0;
    rst_n = 0;
    q.delete();
    exp_cnt = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_count", op_count, 0);
    chk("midrst_result", result, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("midrst_ready_after", in_ready, 1);
    idle(4);
    chk("midrst_no_stale", out_valid, 0);
    chk("midrst_count_after", op_count, 0);
    send(ADD_, 32'h5, 32'h6, 0, 32'hB, 4'b0000);
    idle(4);
    chk("final_count", op_count, 1);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
